i2c_cfg_sequencer: RTL and testbench

Sequences the codec/ADC register initialisation and runtime register writes onto one shared byte-write I2C master. It replays a fixed 8-entry init table after `start`, then arbitrates single user writes onto the same master. It handles NACK retry, transaction timeout, inter-write gap and error reporting. It sits between the system control logic and the bit-level I2C master.

---
 rtl/i2c_cfg_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: replays an 8-entry codec init table, then forwards user register writes, onto one byte-write I2C master
//   clk, reset (async, active-low)
//   start                                   begin init replay (accepted in IDLE or FAIL)
//   usr_valid/usr_reg/usr_data -> usr_ready user write request / accept
//   usr_done/usr_err                        user write outcome pulse
//   m_req/m_dev_addr/m_reg_addr/m_data      request to the I2C master
//   m_done/m_nack                           completion from the I2C master
//   busy, cfg_done, error, err_index        status
module i2c_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h48,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYCLES     = 500,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       usr_valid,
    input  logic [7:0] usr_reg,
    input  logic [7:0] usr_data,
    output logic       usr_ready,
    output logic       usr_done,
    output logic       usr_err,
    output logic       m_req,
    output logic [6:0] m_dev_addr,
    output logic [7:0] m_reg_addr,
    output logic [7:0] m_data,
    input  logic       m_done,
    input  logic       m_nack,
    output logic       busy,
    output logic       cfg_done,
    output logic       error,
    output logic [2:0] err_index
);
    localparam int              GW        = $clog2(GAP_CYCLES + 1);
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);
    // {reg, data}, entry 0 in the low slot
    localparam logic [7:0][15:0] TBL = {16'h0010, 16'h0203, 16'h0100, 16'h0201,
                                        16'h0482, 16'h0300, 16'h1A11, 16'h1D00};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RUN, USR_WAIT, USR_GAP, FAIL} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d, retry_q, retry_d, err_index_q, err_index_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    reg_addr_q, reg_addr_d, data_q, data_d;
    logic          req_q, req_d, usr_done_q, usr_done_d, usr_err_q, usr_err_d;
    logic          cfg_done_q, cfg_done_d, error_q, error_d, rpend_q, rpend_d;
    logic          ok, bad, again;

    // a real m_done always beats a timeout landing on the same cycle
    assign ok    = m_done & ~m_nack;
    assign bad   = m_done ? m_nack : (tmo_q == TMO_LAST);
    assign again = bad & (retry_q < RETRY_MAX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        req_d       = req_q;
        reg_addr_d  = reg_addr_q;
        data_d      = data_q;
        usr_done_d  = 1'b0;
        usr_err_d   = 1'b0;
        cfg_done_d  = cfg_done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        rpend_d     = rpend_q;
        case (state_q)
            IDLE, FAIL: if (start) begin
                idx_d       = '0;
                retry_d     = '0;
                error_d     = 1'b0;
                err_index_d = '0;
                cfg_done_d  = 1'b0;
                state_d     = ISSUE;
            end
            ISSUE: begin
                req_d      = 1'b1;
                reg_addr_d = TBL[idx_q][15:8];
                data_d     = TBL[idx_q][7:0];
                tmo_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (ok) begin
                    req_d   = 1'b0;
                    retry_d = '0;
                    gap_d   = '0;
                    if (idx_q == 3'd7) begin
                        cfg_done_d = 1'b1;
                        state_d    = RUN;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = GAP;
                    end
                end else if (bad) begin
                    req_d = 1'b0;
                    gap_d = '0;
                    if (again) begin
                        retry_d = retry_q + 3'd1;
                        state_d = GAP;
                    end else begin
                        error_d     = 1'b1;
                        err_index_d = idx_q;
                        state_d     = FAIL;
                    end
                end
            end
            GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == GAP_LAST) ? ISSUE : GAP;
            end
            RUN: if (usr_valid) begin
                req_d      = 1'b1;
                reg_addr_d = usr_reg;
                data_d     = usr_data;
                tmo_d      = '0;
                retry_d    = '0;
                state_d    = USR_WAIT;
            end
            USR_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (ok | bad) begin
                    req_d      = 1'b0;
                    gap_d      = '0;
                    rpend_d    = again;
                    retry_d    = again ? retry_q + 3'd1 : '0;
                    usr_done_d = ~again;
                    usr_err_d  = bad & ~again;
                    state_d    = USR_GAP;
                end
            end
            USR_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GAP_LAST) begin
                    // retry re-issues the latched user fields straight from the gap
                    req_d   = rpend_q;
                    tmo_d   = '0;
                    state_d = rpend_q ? USR_WAIT : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            req_q       <= 1'b0;
            reg_addr_q  <= '0;
            data_q      <= '0;
            usr_done_q  <= 1'b0;
            usr_err_q   <= 1'b0;
            cfg_done_q  <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            rpend_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            req_q       <= req_d;
            reg_addr_q  <= reg_addr_d;
            data_q      <= data_d;
            usr_done_q  <= usr_done_d;
            usr_err_q   <= usr_err_d;
            cfg_done_q  <= cfg_done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            rpend_q     <= rpend_d;
        end
    end

    assign usr_ready  = usr_valid & (state_q == RUN);
    assign busy       = !(state_q inside {IDLE, RUN, FAIL});
    assign m_req      = req_q;
    assign m_dev_addr = DEV_ADDR;
    assign m_reg_addr = reg_addr_q;
    assign m_data     = data_q;
    assign usr_done   = usr_done_q;
    assign usr_err    = usr_err_q;
    assign cfg_done   = cfg_done_q;
    assign error      = error_q;
    assign err_index  = err_index_q;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: scoreboard bench with a response-driven I2C master model
module tb_i2c_cfg_sequencer;
    localparam int MAX_RETRY = 3;
    localparam int GAP       = 20;
    localparam int TMO       = 1000;
    localparam int ACK = 0, NACK = 1, TOUT = 2;

    logic       clk = 0, reset = 0, start = 0, usr_valid = 0, m_done = 0, m_nack = 0;
    logic [7:0] usr_reg = 0, usr_data = 0;
    logic       usr_ready, usr_done, usr_err, m_req, busy, cfg_done, error;
    logic [6:0] m_dev_addr;
    logic [7:0] m_reg_addr, m_data;
    logic [2:0] err_index;

    i2c_cfg_sequencer #(.DEV_ADDR(7'h48), .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .usr_valid(usr_valid), .usr_reg(usr_reg),
        .usr_data(usr_data), .usr_ready(usr_ready), .usr_done(usr_done), .usr_err(usr_err),
        .m_req(m_req), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr), .m_data(m_data),
        .m_done(m_done), .m_nack(m_nack), .busy(busy), .cfg_done(cfg_done), .error(error),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         k;
        bit         gap;
    } txn_t;

    txn_t       exp_q[$];
    int         resp_q[$];
    bit         usr_exp_q[$];
    int         passed = 0, total = 0, mode = 0;
    bit         ready_early = 0;
    logic [15:0] tbl [8] = '{16'h1D00, 16'h1A11, 16'h0300, 16'h0482,
                             16'h0201, 16'h0100, 16'h0203, 16'h0010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    // master response for attempt a of table entry idx (idx 8 = user write)
    function automatic int pick(input int idx, input int a);
        int r;
        case (mode)
            0: return ACK;
            1: return (idx == 3 && a < 2) ? NACK : ACK;
            2: return (idx == 5) ? NACK : ACK;
            3: return TOUT;
            default: begin
                r = $urandom_range(0, 99);
                return r < 70 ? ACK : (r < 97 ? NACK : TOUT);
            end
        endcase
    endfunction

    // one logical write: up to MAX_RETRY+1 attempts, stops at the first ACK
    task automatic add_write(input int idx, input logic [7:0] r, input logic [7:0] d,
                             input bit first_gap, output bit ok);
        ok = 0;
        for (int a = 0; a <= MAX_RETRY && !ok; a++) begin
            int k;
            k = pick(idx, a);
            exp_q.push_back('{r, d, k, (a > 0) || first_gap});
            resp_q.push_back(k);
            ok = (k == ACK);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0 || usr_exp_q.size() != 0) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 40000, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        resp_q.delete();
        usr_exp_q.delete();
        reset = 1;
    endtask

    task automatic run_init(input int m, input bit hold, input bit do_reset);
        bit ok;
        bit exp_cfg = 1, exp_err = 0;
        int exp_ei = 0, n = 0;
        if (do_reset) pulse_reset();
        mode = m;
        for (int i = 0; i < 8; i++) begin
            add_write(i, tbl[i][15:8], tbl[i][7:0], i > 0, ok);
            if (!ok) begin
                exp_cfg = 0;
                exp_err = 1;
                exp_ei  = i;
                break;
            end
        end
        if (hold) begin
            mode = 0;
            add_write(8, 8'h10, 8'h5A, 0, ok);
            usr_exp_q.push_back(0);
            usr_valid = 1;
            usr_reg   = 8'h10;
            usr_data  = 8'h5A;
        end
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("start_clears_error", error, 0);
        chk("start_clears_cfg_done", cfg_done, 0);
        if (hold) begin
            repeat (5) @(negedge clk);
            chk("usr_held_off", usr_ready, 0);
        end
        while (!(cfg_done || error) && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk("init_finished", cfg_done || error, 1);
        if (hold) begin
            n = 0;
            while (!usr_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("held_accept", usr_ready, 1);
            @(negedge clk) usr_valid = 0;
        end
        wait_idle("init_idle");
        chk("cfg_done", cfg_done, exp_cfg);
        chk("error", error, exp_err);
        chk("err_index", err_index, exp_ei);
        chk("m_req_idle", m_req, 0);
        chk("busy_idle", busy, 0);
        if (hold) chk("ready_before_run", ready_early, 0);
    endtask

    task automatic usr_write(input int m, input logic [7:0] r, input logic [7:0] d);
        bit ok;
        mode = m;
        add_write(8, r, d, 0, ok);
        usr_exp_q.push_back(!ok);
        @(negedge clk);
        usr_valid = 1;
        usr_reg   = r;
        usr_data  = d;
        #1 chk("usr_ready", usr_ready, 1);
        @(negedge clk) usr_valid = 0;
        wait_idle("usr_idle");
    endtask

    // master model: consumes one planned response per request
    int  m_kind, m_lat;
    bit  m_active = 0;
    initial begin
        forever begin
            @(negedge clk);
            m_done = 0;
            m_nack = 0;
            if (m_req && !m_active) begin
                m_active = 1;
                m_kind   = resp_q.size() != 0 ? resp_q.pop_front() : ACK;
                m_lat    = $urandom_range(1, 25);
            end else if (m_active) begin
                if (!m_req) m_active = 0;
                else if (m_kind != TOUT && --m_lat == 0) begin
                    m_done   = 1;
                    m_nack   = (m_kind == NACK);
                    m_active = 0;
                end
            end
        end
    end

    // scoreboard monitor
    bit         prev_req = 0, stable;
    int         hi = 0, low = 0, cur_k;
    logic [7:0] cur_r, cur_d;
    txn_t       e;
    initial begin
        forever begin
            @(negedge clk);
            if (usr_ready && !cfg_done) ready_early = 1;
            if (m_req && !prev_req) begin
                hi     = 0;
                stable = 1;
                cur_r  = m_reg_addr;
                cur_d  = m_data;
                cur_k  = ACK;
                chk("dev_addr", m_dev_addr, 7'h48);
                if (exp_q.size() == 0) chk("txn_expected", 0, 1);
                else begin
                    e     = exp_q.pop_front();
                    cur_k = e.k;
                    chk("txn_reg", m_reg_addr, e.r);
                    chk("txn_data", m_data, e.d);
                    if (e.gap) chk("txn_gap_ge_min", low >= GAP, 1);
                end
            end
            if (m_req) begin
                hi++;
                if (m_reg_addr !== cur_r || m_data !== cur_d) stable = 0;
            end
            if (!m_req && prev_req) begin
                chk("txn_fields_stable", stable, 1);
                if (cur_k == TOUT) chk("timeout_len", hi, TMO);
                low = 0;
            end
            if (!m_req) low++;
            prev_req = m_req;
            if (usr_done) begin
                if (usr_exp_q.size() == 0) chk("usr_done_expected", 0, 1);
                else chk("usr_err", usr_err, usr_exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_usr_done", usr_done, 0);
        chk("rst_m_reg_addr", m_reg_addr, 0);
        chk("rst_m_data", m_data, 0);
        reset = 1;

        run_init(0, 0, 0);
        usr_write(0, 8'h10, 8'h5A);
        for (int i = 0; i < 5; i++) usr_write(4, 8'($urandom), 8'($urandom));
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("start_ignored_in_run", busy, 0);
        chk("start_ignored_m_req", m_req, 0);

        run_init(1, 0, 1);
        run_init(2, 0, 1);
        run_init(0, 0, 0);
        run_init(3, 0, 1);
        run_init(0, 1, 1);

        pulse_reset();
        mode = 0;
        for (int i = 0; i < 8; i++) begin
            bit ok;
            add_write(i, tbl[i][15:8], tbl[i][7:0], i > 0, ok);
        end
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n = 0;
        while (!(m_req && m_reg_addr == 8'h03) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_entry2", m_req && m_reg_addr == 8'h03, 1);
        @(posedge clk);
        #2 reset = 0;
        #1;
        chk("arst_m_req", m_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_m_reg_addr", m_reg_addr, 0);
        chk("arst_m_data", m_data, 0);
        exp_q.delete();
        resp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1;
        run_init(0, 0, 0);

        for (int r = 0; r < 3; r++) begin
            run_init(4, 0, 1);
            if (cfg_done)
                for (int i = 0; i < 3; i++) usr_write(4, 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
